// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: fetch FSM states and fetch constants shared by the fetch slice
package inst_fetch_unit_pkg;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} fetch_state_t;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_BLOCK_BYTES = 32'd8;
endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: one-outstanding I-cache fetcher feeding the dual-write instruction FIFO
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fifo_full,
    output logic        req_valid,
    output logic [31:0] req_addr,
    output logic        req_pair,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data1,
    input  logic [31:0] resp_data2,
    input  logic        resp_tlb_refill,
    input  logic        resp_tlb_invalid,
    output logic        fifo_rst,
    output logic        write_en1,
    output logic        write_en2,
    output logic [31:0] write_address1,
    output logic [31:0] write_address2,
    output logic [31:0] write_data1,
    output logic [31:0] write_data2,
    output logic        write_tlb_refill1,
    output logic        write_tlb_refill2,
    output logic        write_tlb_invalid1,
    output logic        write_tlb_invalid2
);
    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic         r_req_pair;
    logic [31:0]  w_next_pc;
    logic         w_accept;
    logic         w_fault;
    logic         w_write;

    assign req_valid = (r_state == S_REQ) & !rst & !fifo_full & !redirect_valid;
    assign req_addr  = r_pc;
    assign req_pair  = !r_pc[2];
    assign fifo_rst  = rst | redirect_valid;
    assign w_accept  = req_valid & req_ready;
    assign w_fault   = resp_tlb_refill | resp_tlb_invalid;
    assign w_write   = (r_state == S_WAIT) & resp_valid & !redirect_valid & !rst;
    // A faulting pair only commits slot 1, carrying the flags with zeroed data
    assign write_en1          = w_write;
    assign write_en2          = w_write & r_req_pair & !w_fault;
    assign write_address1     = write_en1 ? r_req_pc : '0;
    assign write_address2     = write_en2 ? r_req_pc + 32'd4 : '0;
    assign write_data1        = (write_en1 & !w_fault) ? resp_data1 : '0;
    assign write_data2        = write_en2 ? resp_data2 : '0;
    assign write_tlb_refill1  = write_en1 & resp_tlb_refill;
    assign write_tlb_invalid1 = write_en1 & resp_tlb_invalid;
    assign write_tlb_refill2  = write_en2 & resp_tlb_refill;
    assign write_tlb_invalid2 = write_en2 & resp_tlb_invalid;
    assign w_next_pc = redirect_valid ? redirect_pc
                     : w_accept ? {r_pc[31:3], 3'b000} + FETCH_BLOCK_BYTES : r_pc;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ:   w_next_state = w_accept ? S_WAIT : S_REQ;
            S_WAIT:  w_next_state = redirect_valid ? (resp_valid ? S_REQ : S_DROP)
                                  : resp_valid ? (w_fault ? S_HALT : S_REQ) : S_WAIT;
            // The dead response retires the outstanding request even under a new redirect
            S_DROP:  w_next_state = resp_valid ? S_REQ : S_DROP;
            S_HALT:  w_next_state = redirect_valid ? S_REQ : S_HALT;
            default: w_next_state = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_req_pair <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_accept) begin
                r_req_pc   <= r_pc;
                r_req_pair <= !r_pc[2];
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: vector table plus write scoreboard for the fetch unit
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_pair;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data1;
    logic [31:0] resp_data2;
    logic        resp_tlb_refill;
    logic        resp_tlb_invalid;
    logic        fifo_rst;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic        write_tlb_refill1;
    logic        write_tlb_refill2;
    logic        write_tlb_invalid1;
    logic        write_tlb_invalid2;

    typedef struct {
        logic        en1, en2;
        logic [31:0] a1, a2, d1, d2;
        logic        rf1, iv1, rf2, iv2;
    } exp_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        int          full;
        logic        refill;
        logic        invalid;
        logic [31:0] addr;
        logic        pair;
    } row_t;

    exp_t sb[$];
    row_t rows[6];
    int   n_cmp = 0;
    int   n_fail = 0;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fifo_full(fifo_full), .req_valid(req_valid), .req_addr(req_addr), .req_pair(req_pair),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data1(resp_data1),
        .resp_data2(resp_data2), .resp_tlb_refill(resp_tlb_refill),
        .resp_tlb_invalid(resp_tlb_invalid), .fifo_rst(fifo_rst), .write_en1(write_en1),
        .write_en2(write_en2), .write_address1(write_address1), .write_address2(write_address2),
        .write_data1(write_data1), .write_data2(write_data2),
        .write_tlb_refill1(write_tlb_refill1), .write_tlb_refill2(write_tlb_refill2),
        .write_tlb_invalid1(write_tlb_invalid1), .write_tlb_invalid2(write_tlb_invalid2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f1(input logic [31:0] a);
        return a ^ 32'h5A5A_0001;
    endfunction

    function automatic logic [31:0] f2(input logic [31:0] a);
        return a ^ 32'hC3C3_0002;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic rf, input logic iv);
        exp_t m;
        logic flt;
        flt   = rf | iv;
        m.en1 = 1'b1;
        m.en2 = !a[2] && !flt;
        m.a1  = a;
        m.a2  = m.en2 ? a + 32'd4 : 32'd0;
        m.d1  = flt ? 32'd0 : f1(a);
        m.d2  = m.en2 ? f2(a) : 32'd0;
        m.rf1 = rf;
        m.iv1 = iv;
        m.rf2 = m.en2 & rf;
        m.iv2 = m.en2 & iv;
        return m;
    endfunction

    function automatic exp_t dead();
        exp_t m;
        m = '{1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue want one entry");
            return;
        end
        e = sb.pop_front();
        chk("write_en1", 32'(write_en1), 32'(e.en1));
        chk("write_en2", 32'(write_en2), 32'(e.en2));
        chk("write_address1", write_address1, e.a1);
        chk("write_address2", write_address2, e.a2);
        chk("write_data1", write_data1, e.d1);
        chk("write_data2", write_data2, e.d2);
        chk("write_tlb_refill1", 32'(write_tlb_refill1), 32'(e.rf1));
        chk("write_tlb_invalid1", 32'(write_tlb_invalid1), 32'(e.iv1));
        chk("write_tlb_refill2", 32'(write_tlb_refill2), 32'(e.rf2));
        chk("write_tlb_invalid2", 32'(write_tlb_invalid2), 32'(e.iv2));
    endtask

    task automatic drive_resp(input logic [31:0] a, input logic rf, input logic iv);
        resp_valid       = 1'b1;
        resp_data1       = f1(a);
        resp_data2       = f2(a);
        resp_tlb_refill  = rf;
        resp_tlb_invalid = iv;
    endtask

    task automatic clear_resp();
        resp_valid       = 1'b0;
        resp_data1       = '0;
        resp_data2       = '0;
        resp_tlb_refill  = 1'b0;
        resp_tlb_invalid = 1'b0;
    endtask

    task automatic issue(input string name, input logic [31:0] a, input logic pair,
                         input logic rf, input logic iv);
        #1;
        chk({name, " req_valid"}, 32'(req_valid), 32'd1);
        chk({name, " req_addr"}, req_addr, a);
        chk({name, " req_pair"}, 32'(req_pair), 32'(pair));
        req_ready = 1'b1;
        sb.push_back(model(a, rf, iv));
        cyc();
        req_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{1'b0, 32'h0,         0, 1'b0, 1'b0, 32'hBFC0_0000, 1'b1};
        rows[1] = '{1'b0, 32'h0,         5, 1'b0, 1'b0, 32'hBFC0_0008, 1'b1};
        rows[2] = '{1'b1, 32'h8000_0104, 0, 1'b0, 1'b0, 32'h8000_0104, 1'b0};
        rows[3] = '{1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h8000_0108, 1'b1};
        rows[4] = '{1'b0, 32'h0,         0, 1'b1, 1'b0, 32'h8000_0110, 1'b1};
        rows[5] = '{1'b1, 32'h8000_0200, 2, 1'b0, 1'b1, 32'h8000_0200, 1'b1};
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fifo_full = 1'b0;
        req_ready = 1'b0;
        clear_resp();
        cyc();
        cyc();
        chk("reset req_valid", 32'(req_valid), 32'd0);
        chk("reset fifo_rst", 32'(fifo_rst), 32'd1);
        chk("reset write_en1", 32'(write_en1), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset fifo_rst", 32'(fifo_rst), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (rows[i].redir) begin
                redirect_valid = 1'b1;
                redirect_pc = rows[i].rpc;
                #1;
                chk("redirect fifo_rst", 32'(fifo_rst), 32'd1);
                chk("redirect req_valid", 32'(req_valid), 32'd0);
                cyc();
                redirect_valid = 1'b0;
            end
            if (rows[i].full > 0) begin
                fifo_full = 1'b1;
                repeat (rows[i].full) begin
                    #1;
                    chk("full req_valid", 32'(req_valid), 32'd0);
                    cyc();
                end
                fifo_full = 1'b0;
            end
            issue($sformatf("row%0d", i), rows[i].addr, rows[i].pair, rows[i].refill, rows[i].invalid);
            drive_resp(rows[i].addr, rows[i].refill, rows[i].invalid);
            #1;
            chk("wait req_valid", 32'(req_valid), 32'd0);
            check_writes();
            cyc();
            clear_resp();
            if (rows[i].refill | rows[i].invalid) begin
                repeat (3) begin
                    #1;
                    chk("halt req_valid", 32'(req_valid), 32'd0);
                    cyc();
                end
            end
        end
        // redirect while a request is outstanding; its late response is dead
        redirect_valid = 1'b1;
        redirect_pc = 32'hBFC0_0010;
        cyc();
        redirect_valid = 1'b0;
        issue("pre-kill", 32'hBFC0_0010, 1'b1, 1'b0, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_2000;
        #1;
        chk("kill fifo_rst", 32'(fifo_rst), 32'd1);
        chk("kill write_en1", 32'(write_en1), 32'd0);
        if (sb.size() > 0) sb[0] = dead();
        cyc();
        redirect_valid = 1'b0;
        drive_resp(32'hBFC0_0010, 1'b0, 1'b0);
        #1;
        chk("drop req_valid", 32'(req_valid), 32'd0);
        check_writes();
        cyc();
        clear_resp();
        issue("after-drop", 32'h8000_2000, 1'b1, 1'b0, 1'b0);
        // redirect in the same cycle as the response
        drive_resp(32'h8000_2000, 1'b0, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_3004;
        #1;
        chk("coincide fifo_rst", 32'(fifo_rst), 32'd1);
        if (sb.size() > 0) sb[0] = dead();
        check_writes();
        cyc();
        clear_resp();
        redirect_valid = 1'b0;
        issue("after-coincide", 32'h8000_3004, 1'b0, 1'b0, 1'b0);
        drive_resp(32'h8000_3004, 1'b0, 1'b0);
        #1;
        check_writes();
        cyc();
        clear_resp();
        issue("next-block", 32'h8000_3008, 1'b1, 1'b0, 1'b0);
        chk("scoreboard residue", 32'(sb.size()), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Fetch-side producer for the dual-write instruction FIFO. Holds the fetch PC, issues one I-cache request at a time for an aligned 8-byte pair, and writes the returned instructions, addresses and TLB flags into the FIFO write ports. It resets the FIFO on redirect and discards in-flight responses that belong to a dead path. Sits between the PC/redirect logic of the execute stage and the instruction FIFO.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  kill current path; restart fetch at redirect_pc.
- redirect_pc  in  32  first address to fetch on the new path, word aligned.
- fifo_full  in  1  FIFO cannot accept two entries.
- req_valid  out  1  I-cache request valid.
- req_addr  out  32  request address, equal to the current fetch PC.
- req_pair  out  1  request two words, asserted when req_addr[2]==0.
- req_ready  in  1  I-cache accepts the request this cycle.
- resp_valid  in  1  response valid, one cycle per accepted request.
- resp_data1, resp_data2  in  32 each  instruction at req_addr and at req_addr+4.
- resp_tlb_refill, resp_tlb_invalid  in  1 each  translation fault for the request.
- fifo_rst  out  1  FIFO pointer reset.
- write_en1, write_en2  out  1 each  FIFO slot writes.
- write_address1, write_address2  out  32 each  PCs.
- write_data1, write_data2  out  32 each  instructions.
- write_tlb_refill1/2, write_tlb_invalid1/2  out  1 each  fault flags.

## Operation
- State: pc[31:0], req_pc[31:0] (PC of the outstanding request), req_pair_q, FSM {REQ, WAIT, DROP, HALT}.
- REQ: req_valid = !rst & !fifo_full & !redirect_valid. On req_valid & req_ready: req_pc<=pc, req_pair_q<=!pc[2], pc<={pc[31:3],3'b0}+8, go to WAIT.
- WAIT: on resp_valid & !redirect_valid, write to the FIFO and go to REQ.
  - No fault: write_en1=1, write_en2=req_pair_q.
  - Fault (refill|invalid): only slot 1 is written. write_data1=0, flags are copied, write_en2=0. Go to HALT instead of REQ.
- Write fields: write_address1=req_pc, write_address2=req_pc+4, write_data1/2=resp_data1/2. Slot-2 flags are the same as slot 1. All write_* fields are 0 when the corresponding enable is 0.
- DROP: the outstanding response is dead. On resp_valid, write nothing and go to REQ.
- HALT: no requests. Leave only on redirect.
- Redirect (any state): fifo_rst=1 for that cycle, all write_en forced 0, and pc<=redirect_pc.
  - Next state: WAIT→DROP, DROP→DROP, REQ→REQ, HALT→REQ.
  - WAIT with resp_valid in the same cycle: the response is dropped and the next state is REQ.
- fifo_rst = rst | redirect_valid.
- Flow control: only one request is ever outstanding, and requests are issued only when !fifo_full. Every response can therefore be written without a check. Full is never re-evaluated at response time.
- PC arithmetic is 32-bit wrap-around; 32'hFFFF_FFF8+8 = 0.

## Timing
- Reset values: state=REQ, pc=RESET_PC, req_valid=0, fifo_rst=1 during rst, all write_* = 0.
- First request: in the cycle after rst deasserts, if fifo_full=0.
- Response to FIFO write: write_en is asserted combinationally in the resp_valid cycle, and the FIFO captures it at the next edge.
- resp_valid never arrives in the accept cycle. Minimum request-to-request spacing is 2 cycles: accept, response, then the next request.
- Redirect takes effect in the same cycle. A request carrying the new PC can be issued in the following cycle from REQ.

## Structure
- Shared package: fetch_state_t enum, RESET_PC default constant, FETCH_BLOCK_BYTES=8.
- No sub-module. Next-PC and alignment logic stay inline. Roughly 150–200 lines of RTL.

## Test plan
- Reset, then pc=BFC0_0000: req_pair=1. Response with ready next cycle → write_en1=write_en2=1, addresses BFC0_0000/BFC0_0004. Next req_addr=BFC0_0008.
- Redirect to 8000_0104: req_pair=0. Response → write_en1=1, write_en2=0, address 8000_0104. Next req_addr=8000_0108.
- Redirect to 8000_2000 while in WAIT (request for BFC0_0010 outstanding): fifo_rst pulses. The late response writes nothing. Next request is 8000_2000.
- fifo_full=1 for 5 cycles in REQ: req_valid stays 0. After full drops, the request issues with an unchanged address.
- Response with resp_tlb_refill=1: write_en1=1, write_tlb_refill1=1, data1=0, write_en2=0. No requests follow until a redirect, after which the next request uses redirect_pc.
- Redirect coinciding with resp_valid in WAIT: no write, fifo_rst=1, next cycle req_addr=redirect_pc.
